// File: rtl/mod_updown_counter_pkg.sv
// mod_updown_counter_pkg: shared boundary-mode encodings for the up/down counter
package mod_updown_counter_pkg;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
endpackage

// File: rtl/mod_updown_counter_next_val.sv
// counter_next_val: combinational step, bound check and load clamp for the counter
module counter_next_val
    import mod_updown_counter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] i_count,
    input  logic         i_up,
    input  logic         i_sat,
    input  logic [N-1:0] i_limit,
    input  logic [N-1:0] i_data,
    output logic [N-1:0] o_step,
    output logic [N-1:0] o_load,
    output logic         o_at_bound,
    output logic         o_wrap
);
    logic [N-1:0] w_up_val;
    logic [N-1:0] w_dn_val;

    assign o_at_bound = i_up ? (i_count >= i_limit) : (i_count == '0);
    assign o_wrap     = o_at_bound & (i_sat == MODE_WRAP);
    assign w_up_val   = o_at_bound ? ((i_sat == MODE_SAT) ? i_limit : '0) : i_count + N'(1);
    assign w_dn_val   = o_at_bound ? ((i_sat == MODE_SAT) ? '0 : i_limit) : i_count - N'(1);
    assign o_step     = i_up ? w_up_val : w_dn_val;
    assign o_load     = (i_data > i_limit) ? i_limit : i_data;
endmodule

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: bounded up/down counter with wrap/saturate modes, load and clear
module mod_updown_counter
    import mod_updown_counter_pkg::*;
#(
    parameter int          N         = 4,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic         up,
    input  logic         load,
    input  logic [N-1:0] data,
    input  logic [N-1:0] limit,
    input  logic         sat,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         wrap
);
    localparam logic [N-1:0] L_RESET = N'(RESET_VAL);

    logic [N-1:0] r_count;
    logic         r_wrap;
    logic [N-1:0] w_step;
    logic [N-1:0] w_load;
    logic         w_at_bound;
    logic         w_wrap;

    counter_next_val #(.N(N)) u_next (
        .i_count    (r_count),
        .i_up       (up),
        .i_sat      (sat),
        .i_limit    (limit),
        .i_data     (data),
        .o_step     (w_step),
        .o_load     (w_load),
        .o_at_bound (w_at_bound),
        .o_wrap     (w_wrap)
    );

    // count/wrap update with priority reset > clear > load > step > hold
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= L_RESET;
            r_wrap  <= 1'b0;
        end else if (clear) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (load) begin
            r_count <= w_load;
            r_wrap  <= 1'b0;
        end else if (enable) begin
            r_count <= w_step;
            r_wrap  <= w_wrap;
        end else begin
            r_wrap  <= 1'b0;
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;
    assign tc    = enable & w_at_bound;
endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: table-driven scoreboard bench for the up/down counter
module tb_mod_updown_counter;
    localparam int N  = 4;
    localparam int RV = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         clear = 1'b0;
    logic         enable = 1'b0;
    logic         up = 1'b0;
    logic         load = 1'b0;
    logic         sat = 1'b0;
    logic [N-1:0] data = '0;
    logic [N-1:0] limit = 4'd9;
    logic [N-1:0] count;
    logic         tc;
    logic         wrap;

    typedef struct {
        logic       r, c, l, e, u, s;
        logic [3:0] d, lim;
        logic       tc;
        logic [3:0] cnt;
        logic       w;
    } vec_t;

    typedef struct {
        logic [3:0] cnt;
        logic       w;
        int         idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mod_updown_counter #(.N(N), .RESET_VAL(RV)) dut (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .enable (enable),
        .up     (up),
        .load   (load),
        .data   (data),
        .limit  (limit),
        .sat    (sat),
        .count  (count),
        .tc     (tc),
        .wrap   (wrap)
    );

    function automatic void add(logic r, logic c, logic l, logic e, logic u, logic s,
                                logic [3:0] d, logic [3:0] lim, logic t, logic [3:0] cnt, logic w);
        vec_t v;
        v.r = r; v.c = c; v.l = l; v.e = e; v.u = u; v.s = s;
        v.d = d; v.lim = lim; v.tc = t; v.cnt = cnt; v.w = w;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, int idx, logic [3:0] act, logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        // reset and priority
        add(1,0,0,0,0,0, 0, 9, 0, 3, 0);
        add(1,1,1,1,1,0, 5, 9, 0, 3, 0);
        add(0,1,1,0,0,0, 5, 9, 0, 0, 0);
        add(0,0,1,0,0,0, 5, 9, 0, 5, 0);
        // wrap up through limit 9
        add(0,1,0,0,0,0, 0, 9, 0, 0, 0);
        for (int i = 0; i < 12; i++)
            add(0,0,0,1,1,0, 0, 9, i == 9, 4'((i + 1) % 10), i == 9);
        // saturate down from 2
        add(0,0,1,0,0,1, 2, 9, 0, 2, 0);
        for (int i = 0; i < 5; i++)
            add(0,0,0,1,0,1, 0, 9, i >= 2, (i < 2) ? 4'(1 - i) : 4'd0, 0);
        // load clamp then wrap
        add(0,0,1,0,1,0, 14, 9, 0, 9, 0);
        add(0,0,0,1,1,0, 0, 9, 1, 0, 1);
        // limit shrink below count
        add(0,0,1,0,0,0, 12, 15, 0, 12, 0);
        add(0,0,0,1,1,0, 0, 6, 1, 0, 1);
        add(0,0,1,0,0,0, 12, 15, 0, 12, 0);
        add(0,0,0,1,1,1, 0, 6, 1, 6, 0);
        add(0,0,1,0,0,0, 12, 15, 0, 12, 0);
        add(0,0,0,1,0,0, 0, 6, 0, 11, 0);
        // enable hold, then reset mid-count and at a wrap point
        add(0,0,1,0,1,0, 7, 9, 0, 7, 0);
        for (int i = 0; i < 5; i++)
            add(0,0,0,0,1,0, 0, 9, 0, 7, 0);
        add(1,0,0,1,1,0, 0, 9, 0, 3, 0);
        add(0,0,1,0,1,0, 9, 9, 0, 9, 0);
        add(1,0,0,1,1,0, 0, 9, 1, 3, 0);
        add(0,0,0,1,1,0, 0, 9, 0, 4, 0);
        // limit zero: back-to-back wraps, clear kills pulse, sat suppresses it
        add(0,1,0,0,0,0, 0, 0, 0, 0, 0);
        add(0,0,0,1,1,0, 0, 0, 1, 0, 1);
        add(0,0,0,1,1,0, 0, 0, 1, 0, 1);
        add(0,0,0,1,0,0, 0, 0, 1, 0, 1);
        add(0,1,0,1,1,0, 0, 0, 1, 0, 0);
        add(0,0,0,1,1,1, 0, 0, 1, 0, 0);
        add(0,0,0,0,1,0, 0, 0, 0, 0, 0);
        // wrap down from 0 to limit
        add(0,0,0,1,0,0, 0, 9, 1, 9, 1);
        add(0,0,0,1,0,0, 0, 9, 0, 8, 0);

        @(negedge clk);
        foreach (vecs[i]) begin
            reset = vecs[i].r; clear = vecs[i].c; load = vecs[i].l;
            enable = vecs[i].e; up = vecs[i].u; sat = vecs[i].s;
            data = vecs[i].d; limit = vecs[i].lim;
            #1;
            check("tc", i, {3'b0, tc}, {3'b0, vecs[i].tc});
            e.cnt = vecs[i].cnt; e.w = vecs[i].w; e.idx = i;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check("count", e.idx, count, e.cnt);
            check("wrap", e.idx, {3'b0, wrap}, {3'b0, e.w});
            @(negedge clk);
        end
        check("scoreboard_empty", 0, 4'(sb.size()), 4'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
